// File: rtl/gcd_multi_pkg.sv
// Shared constants for the multi-channel GCD block: word map, status bits, engine states.
package gcd_multi_pkg;

  // Global register block (block index 0), word offsets within the block.
  localparam logic [1:0] OffGlobalStatus = 2'd0;
  localparam logic [1:0] OffIrqEn        = 2'd1;
  localparam logic [1:0] OffDoneClr      = 2'd2;
  localparam logic [1:0] OffReserved     = 2'd3;

  // Channel c occupies block ChBaseBlk + c, i.e. words 4+4c .. 7+4c.
  localparam int unsigned ChBaseBlk = 1;

  // Word offsets within a channel block.
  localparam logic [1:0] OffIn1    = 2'd0;
  localparam logic [1:0] OffIn2    = 2'd1;
  localparam logic [1:0] OffResult = 2'd2;
  localparam logic [1:0] OffStatus = 2'd3;

  // CH_STATUS bit positions.
  localparam int unsigned StatusW      = 4;
  localparam int unsigned StBitPend    = 0;
  localparam int unsigned StBitDone    = 1;
  localparam int unsigned StBitZeroErr = 2;
  localparam int unsigned StBitOverrun = 3;

  // Engine state encoding.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStrip = 3'd2;
  localparam logic [2:0] StAlign = 3'd3;
  localparam logic [2:0] StLoop  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

endpackage

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine, one reduction step per clock.
module gcd_stein_core
  import gcd_multi_pkg::*;
#(
  parameter int unsigned GCDw = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [GCDw-1:0] in1,
  input  logic [GCDw-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [GCDw-1:0] gcd,
  output logic            zero_err
);

  localparam int unsigned KW = $clog2(GCDw) + 1;

  logic [2:0]      state_q, state_d;
  logic [GCDw-1:0] a_q, a_d;
  logic [GCDw-1:0] b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic [GCDw-1:0] res_q, res_d;
  logic            zerr_q, zerr_d;

  // Next-state and datapath step for the Stein reduction.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    zerr_d  = zerr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          k_d     = '0;
          zerr_d  = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // A zero operand makes the answer the other operand; both zero is an error.
        if ((a_q == '0) || (b_q == '0)) begin
          res_d   = a_q | b_q;
          zerr_d  = (a_q == '0) && (b_q == '0);
          state_d = StDone;
        end else begin
          state_d = StStrip;
        end
      end
      StStrip: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 1'b1;
        end else begin
          state_d = StAlign;
        end
      end
      StAlign: begin
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else begin
          state_d = StLoop;
        end
      end
      StLoop: begin
        // a stays odd here; b is reduced until it reaches zero.
        if (b_q == '0) begin
          res_d   = a_q << k_q;
          state_d = StDone;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = b_q;
          b_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      zerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      zerr_q  <= zerr_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign gcd      = res_q;
  assign zero_err = zerr_q;

endmodule

// File: rtl/gcd_multi_ip.sv
// Multi-channel GCD peripheral: Wishbone register file, round-robin arbiter, one shared engine.
module gcd_multi_ip
  import gcd_multi_pkg::*;
#(
  parameter int unsigned GCDw = 32,
  parameter int unsigned Dw   = GCDw,
  parameter int unsigned CH   = 4,
  parameter int unsigned Aw   = 6,
  parameter int unsigned TAGw = 3,
  parameter int unsigned SELw = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Dw-1:0]   s_dat_i,
  input  logic [SELw-1:0] s_sel_i,
  input  logic [Aw-1:0]   s_addr_i,
  input  logic [TAGw-1:0] s_tag_i,
  input  logic            s_stb_i,
  input  logic            s_cyc_i,
  input  logic            s_we_i,
  output logic [Dw-1:0]   s_dat_o,
  output logic            s_ack_o,
  output logic            s_err_o,
  output logic            s_rty_o,
  output logic            irq
);

  localparam int unsigned CHw = (CH > 1) ? $clog2(CH) : 1;

  // Per-channel state.
  logic [GCDw-1:0] in1_q [CH];
  logic [GCDw-1:0] in2_q [CH];
  logic [GCDw-1:0] res_q [CH];
  logic [CH-1:0]   pend_q;
  logic [CH-1:0]   done_q;
  logic [CH-1:0]   zerr_q;
  logic [CH-1:0]   ovr_q;
  logic [CH-1:0]   irq_en_q;

  // Arbiter state.
  logic [CHw-1:0]  rr_ptr_q;
  logic [CHw-1:0]  serve_q;
  logic            grant_valid;
  logic [CHw-1:0]  grant_ch;
  logic [CHw-1:0]  rr_idx;

  // Bus state.
  logic            ack_q;
  logic [Dw-1:0]   dat_q;
  logic            accept;
  logic            wr_acc;
  logic [Aw-3:0]   blk;
  logic [1:0]      off;
  logic            is_glob;
  logic            is_chan;
  logic [CHw-1:0]  ch_sel;
  logic [Dw-1:0]   rdata;
  logic [StatusW-1:0] ch_status;

  // Engine interface.
  logic            eng_busy;
  logic            eng_done;
  logic [GCDw-1:0] eng_gcd;
  logic            eng_zerr;

  // Byte select, tag and any data bits above the operand width carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_sel_i, s_tag_i, s_dat_i};

  // Address decode: word address = {block, offset}.
  assign blk     = s_addr_i[Aw-1:2];
  assign off     = s_addr_i[1:0];
  assign is_glob = (blk == '0);
  assign is_chan = (32'(blk) >= ChBaseBlk) && (32'(blk) < ChBaseBlk + CH);
  assign ch_sel  = CHw'(32'(blk) - ChBaseBlk);

  // An access is taken only while ack is low, so a held strobe cannot double-write.
  assign accept = s_stb_i & s_cyc_i & ~ack_q;
  assign wr_acc = accept & s_we_i;

  // Round-robin search starting at the channel after the last one served.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    rr_idx      = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      rr_idx = CHw'((32'(rr_ptr_q) + i) % CH);
      if (!grant_valid && pend_q[rr_idx]) begin
        grant_valid = 1'b1;
        grant_ch    = rr_idx;
      end
    end
    // The served channel stays pending while the engine runs; only grant when idle.
    if (eng_busy) begin
      grant_valid = 1'b0;
    end
  end

  gcd_stein_core #(
    .GCDw(GCDw)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .start   (grant_valid),
    .in1     (in1_q[grant_ch]),
    .in2     (in2_q[grant_ch]),
    .busy    (eng_busy),
    .done    (eng_done),
    .gcd     (eng_gcd),
    .zero_err(eng_zerr)
  );

  // Track which channel the engine is working on and where the next search begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      serve_q  <= '0;
    end else if (grant_valid) begin
      serve_q  <= grant_ch;
      rr_ptr_q <= (grant_ch == CHw'(CH - 1)) ? '0 : grant_ch + 1'b1;
    end
  end

  // Register file updates from bus writes and engine completion; completion is applied last
  // so a done set beats a simultaneous DONE_CLR on the same channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CH; c++) begin
        in1_q[c] <= '0;
        in2_q[c] <= '0;
        res_q[c] <= '0;
      end
      pend_q   <= '0;
      done_q   <= '0;
      zerr_q   <= '0;
      ovr_q    <= '0;
      irq_en_q <= '0;
    end else begin
      if (wr_acc && is_glob && (off == OffIrqEn)) begin
        irq_en_q <= s_dat_i[CH-1:0];
      end
      for (int unsigned c = 0; c < CH; c++) begin
        if (wr_acc && is_chan && (ch_sel == CHw'(c))) begin
          if ((off == OffIn1) && !pend_q[c]) begin
            in1_q[c] <= s_dat_i[GCDw-1:0];
          end
          if (off == OffIn2) begin
            if (!pend_q[c]) begin
              in2_q[c]  <= s_dat_i[GCDw-1:0];
              pend_q[c] <= 1'b1;
              done_q[c] <= 1'b0;
              zerr_q[c] <= 1'b0;
              ovr_q[c]  <= 1'b0;
            end else begin
              ovr_q[c] <= 1'b1;
            end
          end
        end
        if (wr_acc && is_glob && (off == OffDoneClr) && s_dat_i[c]) begin
          done_q[c] <= 1'b0;
        end
        if (eng_done && (serve_q == CHw'(c))) begin
          res_q[c]  <= eng_gcd;
          pend_q[c] <= 1'b0;
          done_q[c] <= 1'b1;
          zerr_q[c] <= eng_zerr;
        end
      end
    end
  end

  // Read data mux; unused bits and unmapped words read zero.
  always_comb begin
    rdata     = '0;
    ch_status = '0;
    ch_status[StBitPend]    = pend_q[ch_sel];
    ch_status[StBitDone]    = done_q[ch_sel];
    ch_status[StBitZeroErr] = zerr_q[ch_sel];
    ch_status[StBitOverrun] = ovr_q[ch_sel];
    if (is_glob) begin
      case (off)
        OffGlobalStatus: begin
          rdata[CH-1:0]    = done_q;
          rdata[2*CH-1:CH] = pend_q;
        end
        OffIrqEn:    rdata[CH-1:0] = irq_en_q;
        OffDoneClr:  rdata = '0;
        OffReserved: rdata = '0;
        default:     rdata = '0;
      endcase
    end else if (is_chan) begin
      case (off)
        OffIn1:    rdata = Dw'(in1_q[ch_sel]);
        OffIn2:    rdata = Dw'(in2_q[ch_sel]);
        OffResult: rdata = Dw'(res_q[ch_sel]);
        OffStatus: rdata = Dw'(ch_status);
        default:   rdata = '0;
      endcase
    end
  end

  // Registered acknowledge and read data, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        dat_q <= s_we_i ? '0 : rdata;
      end
    end
  end

  assign s_dat_o = dat_q;
  assign s_ack_o = ack_q;
  assign s_err_o = 1'b0;
  assign s_rty_o = 1'b0;
  assign irq     = |(done_q & irq_en_q);

endmodule

// File: tb/tb_gcd_multi_ip.sv
// Directed bench for gcd_multi_ip (CH=4, GCDw=32).
module tb_gcd_multi_ip;

  logic        clk;
  logic        reset;
  logic [31:0] s_dat_i;
  logic [3:0]  s_sel_i;
  logic [5:0]  s_addr_i;
  logic [2:0]  s_tag_i;
  logic        s_stb_i;
  logic        s_cyc_i;
  logic        s_we_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        s_err_o;
  logic        s_rty_o;
  logic        irq;

  int tests;
  int fails;
  int cyc_cnt;

  gcd_multi_ip #(
    .GCDw(32),
    .Dw  (32),
    .CH  (4),
    .Aw  (6),
    .TAGw(3),
    .SELw(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_dat_i (s_dat_i),
    .s_sel_i (s_sel_i),
    .s_addr_i(s_addr_i),
    .s_tag_i (s_tag_i),
    .s_stb_i (s_stb_i),
    .s_cyc_i (s_cyc_i),
    .s_we_i  (s_we_i),
    .s_dat_o (s_dat_o),
    .s_ack_o (s_ack_o),
    .s_err_o (s_err_o),
    .s_rty_o (s_rty_o),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [5:0] a_in1(input int c);
    return 6'(4 + 4 * c);
  endfunction
  function automatic logic [5:0] a_in2(input int c);
    return 6'(5 + 4 * c);
  endfunction
  function automatic logic [5:0] a_res(input int c);
    return 6'(6 + 4 * c);
  endfunction
  function automatic logic [5:0] a_st(input int c);
    return 6'(7 + 4 * c);
  endfunction

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
    int n;
    @(posedge clk); #1;
    s_addr_i = addr; s_dat_i = data; s_we_i = 1'b1; s_stb_i = 1'b1; s_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!s_ack_o && n < 8);
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    tests++;
    if (!s_ack_o) begin
      fails++;
      $display("FAIL bus_write_ack addr=%0d got ack=0 want ack=1", addr);
    end
  endtask

  task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    s_addr_i = addr; s_we_i = 1'b0; s_stb_i = 1'b1; s_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!s_ack_o && n < 8);
    data = s_dat_o;
    s_stb_i = 1'b0; s_cyc_i = 1'b0;
    tests++;
    if (!s_ack_o) begin
      fails++;
      $display("FAIL bus_read_ack addr=%0d got ack=0 want ack=1", addr);
    end
  endtask

  task automatic wait_done(input int c, output logic ok);
    logic [31:0] rd;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      bus_read(a_st(c), rd);
      ok = rd[1];
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (s_ack_o !== 1'b0 || s_err_o !== 1'b0 || s_rty_o !== 1'b0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got ack=%b err=%b rty=%b irq=%b want 0000",
               s_ack_o, s_err_o, s_rty_o, irq);
    end
    bus_read(6'd0, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_global got=%h want=0", rd); end
    bus_read(6'd1, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_irq_en got=%h want=0", rd); end
    bus_read(a_res(0), rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_result0 got=%h want=0", rd); end
    bus_read(a_st(2), rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_status2 got=%h want=0", rd); end
    bus_read(6'd3, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reserved_word got=%h want=0", rd); end
    bus_write(a_in1(1), 32'd77);
    bus_read(6'd20, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL unmapped_word got=%h want=0", rd); end
    bus_read(a_in1(1), rd);
    tests++;
    if (rd !== 32'd77) begin fails++; $display("FAIL in1_readback got=%0d want=77", rd); end
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    logic        ok;
    int          t0;
    bus_write(a_in1(0), 32'd48);
    bus_write(a_in2(0), 32'd18);
    t0 = cyc_cnt;
    wait_done(0, ok);
    tests++;
    if (!ok || (cyc_cnt - t0) > 132) begin
      fails++;
      $display("FAIL basic_latency got ok=%b cycles=%0d want done within 132", ok, cyc_cnt - t0);
    end
    bus_read(a_res(0), rd);
    tests++;
    if (rd !== 32'd6) begin fails++; $display("FAIL basic_result got=%0d want=6", rd); end
    bus_read(a_st(0), rd);
    tests++;
    if (rd !== 32'h2) begin fails++; $display("FAIL basic_status got=%h want=2", rd); end
    bus_read(6'd0, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL basic_global got=%h want=1", rd); end
    bus_read(a_in2(0), rd);
    tests++;
    if (rd !== 32'd18) begin fails++; $display("FAIL basic_in2 got=%0d want=18", rd); end
  endtask

  task automatic test_ack_single;
    logic [31:0] rd;
    logic        ok;
    bus_write(a_in1(3), 32'd9);
    // Strobe held across two edges must produce one ack and one write.
    @(posedge clk); #1;
    s_addr_i = a_in2(3); s_dat_i = 32'd6; s_we_i = 1'b1; s_stb_i = 1'b1; s_cyc_i = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (s_ack_o !== 1'b1) begin fails++; $display("FAIL ack_first got=%b want=1", s_ack_o); end
    @(posedge clk); #1;
    tests++;
    if (s_ack_o !== 1'b0) begin fails++; $display("FAIL ack_second got=%b want=0", s_ack_o); end
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    wait_done(3, ok);
    bus_read(a_st(3), rd);
    tests++;
    if (!ok || rd !== 32'h2) begin
      fails++;
      $display("FAIL ack_no_double_write got ok=%b status=%h want status=2", ok, rd);
    end
    bus_read(a_res(3), rd);
    tests++;
    if (rd !== 32'd3) begin fails++; $display("FAIL ack_result got=%0d want=3", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic [3:0]  seen, fresh;
    int          order[4];
    int          pos, amb;
    logic [31:0] exp_res[4];
    logic [31:0] exp_st[4];
    exp_res[0] = 32'd4; exp_res[1] = 32'd7; exp_res[2] = 32'd9; exp_res[3] = 32'd0;
    exp_st[0] = 32'h2; exp_st[1] = 32'h2; exp_st[2] = 32'h2; exp_st[3] = 32'h6;
    bus_write(6'd2, 32'hF);
    bus_write(a_in1(0), 32'd12); bus_write(a_in2(0), 32'd8);
    bus_write(a_in1(1), 32'd35); bus_write(a_in2(1), 32'd14);
    bus_write(a_in1(2), 32'd0);  bus_write(a_in2(2), 32'd9);
    bus_write(a_in1(3), 32'd0);  bus_write(a_in2(3), 32'd0);
    seen = 4'b0; pos = 0; amb = 0;
    for (int c = 0; c < 4; c++) order[c] = -1;
    for (int n = 0; n < 200 && seen != 4'hF; n++) begin
      bus_read(6'd0, rd);
      fresh = rd[3:0] & ~seen;
      if ($countones(fresh) > 1) amb++;
      for (int c = 0; c < 4; c++) if (fresh[c]) order[c] = pos;
      if (fresh != 4'b0) pos++;
      seen = seen | rd[3:0];
    end
    tests++;
    if (amb != 0 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
      fails++;
      $display("FAIL b2b_order got pos=%0d,%0d,%0d,%0d amb=%0d want 0,1,2,3 amb=0",
               order[0], order[1], order[2], order[3], amb);
    end
    for (int c = 0; c < 4; c++) begin
      bus_read(a_res(c), rd);
      tests++;
      if (rd !== exp_res[c]) begin
        fails++; $display("FAIL b2b_result%0d got=%0d want=%0d", c, rd, exp_res[c]);
      end
      bus_read(a_st(c), rd);
      tests++;
      if (rd !== exp_st[c]) begin
        fails++; $display("FAIL b2b_status%0d got=%h want=%h", c, rd, exp_st[c]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [31:0] rd;
    logic [3:0]  seen, fresh;
    int          order[4];
    int          pos, amb;
    bus_write(6'd2, 32'hF);
    // Long job on ch1, then ch0 and ch2 queue behind it; search resumes after ch1.
    bus_write(a_in1(1), 32'h7FFF_FFFF); bus_write(a_in2(1), 32'd1);
    bus_write(a_in1(0), 32'd0);         bus_write(a_in2(0), 32'd5);
    bus_write(a_in1(2), 32'd0);         bus_write(a_in2(2), 32'd7);
    seen = 4'b0; pos = 0; amb = 0;
    for (int c = 0; c < 4; c++) order[c] = -1;
    for (int n = 0; n < 300 && (seen & 4'h7) != 4'h7; n++) begin
      bus_read(6'd0, rd);
      fresh = rd[3:0] & ~seen;
      if ($countones(fresh) > 1) amb++;
      for (int c = 0; c < 4; c++) if (fresh[c]) order[c] = pos;
      if (fresh != 4'b0) pos++;
      seen = seen | rd[3:0];
    end
    tests++;
    if (amb != 0 || order[1] != 0 || order[2] != 1 || order[0] != 2) begin
      fails++;
      $display("FAIL rr_order got ch1=%0d ch2=%0d ch0=%0d amb=%0d want 0,1,2 amb=0",
               order[1], order[2], order[0], amb);
    end
    bus_read(a_res(1), rd);
    tests++;
    if (rd !== 32'd1) begin fails++; $display("FAIL rr_result1 got=%0d want=1", rd); end
    bus_read(a_res(2), rd);
    tests++;
    if (rd !== 32'd7) begin fails++; $display("FAIL rr_result2 got=%0d want=7", rd); end
    bus_read(a_res(0), rd);
    tests++;
    if (rd !== 32'd5) begin fails++; $display("FAIL rr_result0 got=%0d want=5", rd); end
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    logic        ok;
    bus_write(6'd2, 32'hF);
    bus_write(6'd1, 32'h2);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle got=%b want=0", irq); end
    bus_write(a_in1(0), 32'd0); bus_write(a_in2(0), 32'd5);
    wait_done(0, ok);
    tests++;
    if (!ok || irq !== 1'b0) begin
      fails++; $display("FAIL irq_masked got ok=%b irq=%b want ok=1 irq=0", ok, irq);
    end
    bus_write(a_in1(1), 32'd21); bus_write(a_in2(1), 32'd6);
    wait_done(1, ok);
    tests++;
    if (!ok || irq !== 1'b1) begin
      fails++; $display("FAIL irq_set got ok=%b irq=%b want ok=1 irq=1", ok, irq);
    end
    bus_write(6'd2, 32'h2);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b want=0", irq); end
    bus_read(6'd0, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL irq_global got=%h want=1", rd); end
    bus_read(a_res(1), rd);
    tests++;
    if (rd !== 32'd3) begin fails++; $display("FAIL irq_result1 got=%0d want=3", rd); end
  endtask

  task automatic test_overrun;
    logic [31:0] rd;
    logic        ok;
    bus_write(a_in1(2), 32'd3145728);
    bus_write(a_in2(2), 32'd3);
    bus_write(a_in1(2), 32'd100);
    bus_write(a_in2(2), 32'd50);
    wait_done(2, ok);
    bus_read(a_st(2), rd);
    tests++;
    if (!ok || rd !== 32'hA) begin
      fails++; $display("FAIL ovr_status got ok=%b status=%h want status=a", ok, rd);
    end
    bus_read(a_res(2), rd);
    tests++;
    if (rd !== 32'd3) begin fails++; $display("FAIL ovr_result got=%0d want=3", rd); end
    bus_read(a_in1(2), rd);
    tests++;
    if (rd !== 32'd3145728) begin fails++; $display("FAIL ovr_in1 got=%0d want=3145728", rd); end
    bus_read(a_in2(2), rd);
    tests++;
    if (rd !== 32'd3) begin fails++; $display("FAIL ovr_in2 got=%0d want=3", rd); end
    bus_write(a_in1(2), 32'd10);
    bus_write(a_in2(2), 32'd4);
    wait_done(2, ok);
    bus_read(a_st(2), rd);
    tests++;
    if (!ok || rd !== 32'h2) begin
      fails++; $display("FAIL ovr_restart_status got ok=%b status=%h want status=2", ok, rd);
    end
    bus_read(a_res(2), rd);
    tests++;
    if (rd !== 32'd2) begin fails++; $display("FAIL ovr_restart_result got=%0d want=2", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int          t0;
    int          irq_hi;
    bus_write(6'd1, 32'h1);
    bus_write(a_in1(0), 32'h8000_0000);
    bus_write(a_in2(0), 32'h4000_0000);
    t0 = cyc_cnt;
    bus_read(a_st(0), rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL mid_busy got=%h want=1", rd); end
    while (cyc_cnt < t0 + 10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    irq_hi = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (irq !== 1'b0) irq_hi++;
    end
    tests++;
    if (irq_hi != 0) begin fails++; $display("FAIL mid_irq got=%0d high cycles want=0", irq_hi); end
    bus_read(6'd0, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_global got=%h want=0", rd); end
    bus_read(a_st(0), rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_status0 got=%h want=0", rd); end
    bus_read(a_res(0), rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_result0 got=%h want=0", rd); end
    bus_read(a_st(2), rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_status2 got=%h want=0", rd); end
    bus_read(6'd1, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL mid_irq_en got=%h want=0", rd); end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    cyc_cnt  = 0;
    reset    = 1'b1;
    s_dat_i  = '0;
    s_sel_i  = 4'hF;
    s_addr_i = '0;
    s_tag_i  = '0;
    s_stb_i  = 1'b0;
    s_cyc_i  = 1'b0;
    s_we_i   = 1'b0;
    test_reset();
    test_basic();
    test_ack_single();
    test_back_to_back();
    test_round_robin();
    test_irq();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
